// File: rtl/pipelined_cla_addsub.sv
// ---------------------------------------------------------------------------
// pipelined_cla_addsub
//
// Pipelined carry-lookahead adder/subtractor with a valid/ready handshake.
// result = a + (sub ? ~b : b) + sub, modulo 2^WIDTH.
//
// The WIDTH-bit datapath is cut into BLOCK-bit CLA groups. Each of the
// STAGES pipeline stages resolves G = WIDTH/(BLOCK*STAGES) consecutive
// groups, doing a lookahead across those groups from the carry handed over
// by the previous stage. The inter-stage carry is registered together with
// the operand bits that are still to be consumed. Latency is exactly
// STAGES cycles. The whole pipeline advances as one unit whenever the
// output register is empty or being drained, so bubbles keep their slot.
//
// Parameters: WIDTH (operand width), BLOCK (CLA group width, divides WIDTH),
//             STAGES (pipeline depth, divides WIDTH/BLOCK, >= 1),
//             TAG_W (sideband tag width).
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_valid / in_ready  input handshake (in_ready = advance)
//   a, b, sub, tag_in    operands, 0 = add / 1 = subtract, sideband tag
//   out_valid/out_ready  output handshake
//   result, tag_out      sum/difference and the tag it was issued with
//   flag_n/z/c/v         negative, zero, carry-out (sub: 1 = no borrow),
//                        signed overflow
//
// Build option: define CLA_ADDSUB_FLAGS_EN to compute and pipeline the
// flags. Without it the flag ports stay in place and are tied to 0.
// ---------------------------------------------------------------------------
module pipelined_cla_addsub #(
  parameter int WIDTH  = 64,
  parameter int BLOCK  = 16,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] tag_out,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int NGRP = WIDTH / BLOCK;   // CLA groups in total
  localparam int G    = NGRP / STAGES;   // CLA groups per stage
  localparam int LAST = STAGES - 1;

  // Carry vector of an n-bit lookahead unit in sum-of-products form:
  // c[j] = g[j-1] | p[j-1]g[j-2] | ... | p[j-1..0]cin.
  function automatic logic [BLOCK:0] bit_carries(input logic [BLOCK-1:0] p,
                                                 input logic [BLOCK-1:0] g,
                                                 input logic             cin);
    logic [BLOCK:0] c;
    logic           term;
    c = '0;
    c[0] = cin;
    for (int j = 1; j <= BLOCK; j++) begin
      term = cin;
      for (int m = 0; m < j; m++) term = term & p[m];
      c[j] = term;
      for (int i = 0; i < j; i++) begin
        term = g[i];
        for (int m = i + 1; m < j; m++) term = term & p[m];
        c[j] = c[j] | term;
      end
    end
    return c;
  endfunction

  // Same lookahead, applied across the group P/G signals of one stage.
  function automatic logic [G:0] group_carries(input logic [G-1:0] p,
                                               input logic [G-1:0] g,
                                               input logic         cin);
    logic [G:0] c;
    logic       term;
    c = '0;
    c[0] = cin;
    for (int j = 1; j <= G; j++) begin
      term = cin;
      for (int m = 0; m < j; m++) term = term & p[m];
      c[j] = term;
      for (int i = 0; i < j; i++) begin
        term = g[i];
        for (int m = i + 1; m < j; m++) term = term & p[m];
        c[j] = c[j] | term;
      end
    end
    return c;
  endfunction

  // Stage registers: register k holds the output of stage k.
  logic             v_q  [STAGES];
  logic             cy_q [STAGES];
  logic [WIDTH-1:0] s_q  [STAGES];
  logic [WIDTH-1:0] a_q  [STAGES];
  logic [WIDTH-1:0] b_q  [STAGES];
  logic [TAG_W-1:0] t_q  [STAGES];

  // Stage inputs (primary inputs for stage 0, previous register otherwise).
  logic             src_v [STAGES];
  logic             src_c [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [TAG_W-1:0] src_t [STAGES];

  // Stage outputs.
  logic [WIDTH-1:0] nxt_s [STAGES];
  logic             nxt_c [STAGES];

  logic advance;

  assign out_valid = v_q[LAST];
  assign result    = s_q[LAST];
  assign tag_out   = t_q[LAST];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_src
    if (k == 0) begin : g_first
      // Subtraction is a + ~b + 1: invert b here and feed sub as carry-in.
      assign src_v[k] = in_valid;
      assign src_c[k] = sub;
      assign src_s[k] = '0;
      assign src_a[k] = a;
      assign src_b[k] = sub ? ~b : b;
      assign src_t[k] = tag_in;
    end else begin : g_next
      assign src_v[k] = v_q[k-1];
      assign src_c[k] = cy_q[k-1];
      assign src_s[k] = s_q[k-1];
      assign src_a[k] = a_q[k-1];
      assign src_b[k] = b_q[k-1];
      assign src_t[k] = t_q[k-1];
    end
  end

  logic [BLOCK-1:0] p_v, g_v;
  logic [BLOCK:0]   bc_v;
  logic [G-1:0]     gp_v, gg_v;
  logic [G:0]       gc_v;
  int               lo;

  // Each stage keeps the sum bits already produced upstream and fills in
  // its own slice; first pass forms group P/G, second pass applies the
  // group carries back to the bits.
  always_comb begin
    // NOTE: every variable written here gets a value before any branch or
    // loop, so no path can leave it holding its old value (no latch).
    p_v  = '0;
    g_v  = '0;
    bc_v = '0;
    gp_v = '0;
    gg_v = '0;
    gc_v = '0;
    lo   = 0;
    for (int k = 0; k < STAGES; k++) begin
      nxt_s[k] = src_s[k];
      for (int j = 0; j < G; j++) begin
        lo      = (k * G + j) * BLOCK;
        p_v     = src_a[k][lo +: BLOCK] ^ src_b[k][lo +: BLOCK];
        g_v     = src_a[k][lo +: BLOCK] & src_b[k][lo +: BLOCK];
        bc_v    = bit_carries(p_v, g_v, 1'b0);
        gp_v[j] = &p_v;
        gg_v[j] = bc_v[BLOCK];
      end
      gc_v = group_carries(gp_v, gg_v, src_c[k]);
      for (int j = 0; j < G; j++) begin
        lo   = (k * G + j) * BLOCK;
        p_v  = src_a[k][lo +: BLOCK] ^ src_b[k][lo +: BLOCK];
        g_v  = src_a[k][lo +: BLOCK] & src_b[k][lo +: BLOCK];
        bc_v = bit_carries(p_v, g_v, gc_v[j]);
        nxt_s[k][lo +: BLOCK] = p_v ^ bc_v[BLOCK-1:0];
      end
      nxt_c[k] = gc_v[G];
    end
  end

  // NOTE: state is written with non-blocking assignments so every register
  // samples the values from before this edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) v_q[k] <= 1'b0;
      s_q[LAST] <= '0;
      t_q[LAST] <= '0;
    end else if (advance) begin
      // NOTE: carries, operands and intermediate sums are not reset; they
      // are meaningless while the matching valid bit is 0.
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]  <= src_v[k];
        cy_q[k] <= nxt_c[k];
        s_q[k]  <= nxt_s[k];
        a_q[k]  <= src_a[k];
        b_q[k]  <= src_b[k];
        t_q[k]  <= src_t[k];
      end
    end
  end

`ifdef CLA_ADDSUB_FLAGS_EN
  logic fn_q, fz_q, fc_q, fv_q;

  // Carry into the MSB is p ^ sum at that bit, so overflow needs no extra
  // tap out of the lookahead tree.
  always_ff @(posedge clk) begin
    if (reset) begin
      fn_q <= 1'b0;
      fz_q <= 1'b0;
      fc_q <= 1'b0;
      fv_q <= 1'b0;
    end else if (advance) begin
      fn_q <= nxt_s[LAST][WIDTH-1];
      fz_q <= (nxt_s[LAST] == '0);
      fc_q <= nxt_c[LAST];
      fv_q <= src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1] ^
              nxt_s[LAST][WIDTH-1] ^ nxt_c[LAST];
    end
  end

  assign flag_n = fn_q;
  assign flag_z = fz_q;
  assign flag_c = fc_q;
  assign flag_v = fv_q;
`else
  assign flag_n = 1'b0;
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
  assign flag_v = 1'b0;
`endif

endmodule
